// File: rtl/rsa_pkg.sv
// Shared constants and the mod_exp control state encoding for the RSA exponentiation datapath.
package rsa_pkg;

  localparam int RSA_W = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    UPD  = 3'd3,
    FIN  = 3'd4
  } exp_state_t;

endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, MSB of a first, one bit per cycle.
// mul_done pulses W cycles after mul_start; p then holds until the next mul_start.
module mod_mul
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mul_start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         mul_done,
  output logic [W-1:0] p
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          run;

  logic [W:0]    n_ext;
  logic [W:0]    dbl;
  logic [W-1:0]  dbl_red;
  logic [W:0]    sum;
  logic [W-1:0]  sum_red;
  logic [W-1:0]  acc_nxt;

  // W+1-bit intermediates: 2*acc and acc+b are both below 2n, so one conditional subtract suffices.
  always_comb begin
    n_ext   = {1'b0, n_r};
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= n_ext) ? W'(dbl - n_ext) : W'(dbl);
    sum     = {1'b0, dbl_red} + {1'b0, b_r};
    sum_red = (sum >= n_ext) ? W'(sum - n_ext) : W'(sum);
    acc_nxt = a_r[W-1] ? sum_red : dbl_red;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (mul_start) begin
      a_r <= a;
      b_r <= b;
      n_r <= n;
      acc <= '0;
      cnt <= CW'(W);
      run <= 1'b1;
    end else if (run) begin
      acc <= acc_nxt;
      a_r <= a_r << 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

  assign mul_done = run && (cnt == CW'(1));
  assign p        = acc;

endmodule

// File: rtl/mod_exp.sv
// Right-to-left square-and-multiply: result = base^exp mod n using two parallel mod_mul units.
// done pulses L*(W+2)+2 cycles after start (2 for errors or exp==0); start is ignored while busy.
module mod_exp
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  exp_state_t   state;
  exp_state_t   state_nxt;

  logic [W-1:0] base_r;
  logic [W-1:0] exp_r;
  logic [W-1:0] n_r;
  logic [W-1:0] acc;
  logic [W-1:0] sq;
  logic [W-1:0] e_r;
  logic         mul_wait;

  logic         mul_start;
  logic         done1;
  logic         done2;
  logic         mul_done;
  logic [W-1:0] p1;
  logic [W-1:0] p2;

  logic         bad_op;
  logic [W-1:0] e_shift;
  logic [W-1:0] acc_upd;

  assign bad_op   = (n_r < W'(2)) || (base_r >= n_r);
  assign e_shift  = e_r >> 1;
  assign acc_upd  = e_r[0] ? p1 : acc;
  assign mul_done = done1 & done2;

  mod_mul #(.W(W)) u_mul_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_start (mul_start),
    .a         (acc),
    .b         (sq),
    .n         (n_r),
    .mul_done  (done1),
    .p         (p1)
  );

  mod_mul #(.W(W)) u_mul_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_start (mul_start),
    .a         (sq),
    .b         (sq),
    .n         (n_r),
    .mul_done  (done2),
    .p         (p2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (bad_op || exp_r == '0) state_nxt = FIN;
        else                       state_nxt = MUL;
      end
      MUL: begin
        // Launch once on entry; mul_wait covers the W cycles the multipliers run.
        mul_start = !mul_wait;
        if (mul_done) state_nxt = UPD;
      end
      UPD: begin
        if (e_shift == '0) state_nxt = FIN;
        else               state_nxt = MUL;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= '0;
      exp_r    <= '0;
      n_r      <= '0;
      acc      <= '0;
      sq       <= '0;
      e_r      <= '0;
      mul_wait <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      if (mul_start)     mul_wait <= 1'b1;
      else if (mul_done) mul_wait <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            n_r    <= n;
          end
        end
        LOAD: begin
          if (bad_op) begin
            err    <= 1'b1;
            result <= '0;
          end else if (exp_r == '0) begin
            err    <= 1'b0;
            result <= W'(1);
          end else begin
            acc <= W'(1);
            sq  <= base_r;
            e_r <= exp_r;
          end
        end
        UPD: begin
          acc <= acc_upd;
          sq  <= p2;
          e_r <= e_shift;
          if (e_shift == '0) begin
            err    <= 1'b0;
            result <= acc_upd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp.sv
// Scoreboarded bench for mod_exp: directed RSA vectors, error cases, ignored starts, reset abort, random ops.
module tb_mod_exp;
  import rsa_pkg::*;

  localparam int W = RSA_W;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           start_cyc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] exp = '0;
  logic [W-1:0] n = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  mod_exp #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Plain modular exponentiation over the exponent bits using double-width products.
  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] r;
    logic [2*W-1:0] x;
    r = 1;
    x = {{W{1'b0}}, b};
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b, input logic [W-1:0] e,
                                 input logic [W-1:0] m);
    int len;
    len = 0;
    for (int i = 0; i < W; i++) if (e[i]) len = i + 1;
    if (m < 2 || b >= m || len == 0) return 2;
    return len * (W + 2) + 2;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || done) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (busy || done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic drive(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    base  = b;
    exp   = e;
    n     = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_k(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                         input logic [W-1:0] r, input logic er);
    exp_t x;
    wait_idle();
    x.res       = r;
    x.err       = er;
    x.start_cyc = cyc;
    x.lat       = ref_lat(b, e, m);
    sb.push_back(x);
    drive(b, e, m);
  endtask

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    logic er;
    er = (m < 2) || (b >= m);
    issue_k(b, e, m, er ? '0 : ref_pow(b, e, m), er);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result", result, x.res);
        check("err", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, x.err});
        check("latency", W'(cyc - x.start_cyc), W'(x.lat));
      end
    end
  end

  initial begin
    logic [W-1:0] rb, re, rn;
    int t;

    repeat (3) @(negedge clk);
    check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
    check("rst_done", {{(W-1){1'b0}}, done}, '0);
    check("rst_err", {{(W-1){1'b0}}, err}, '0);
    check("rst_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    issue_k(4, 13, 497, 445, 1'b0);
    issue_k(65, 17, 3233, 2790, 1'b0);
    issue_k(2790, 2753, 3233, 65, 1'b0);
    issue_k(7, 0, 11, 1, 1'b0);
    issue_k(0, 5, 11, 0, 1'b0);
    issue_k(3, 5, 1, 0, 1'b1);
    issue_k(20, 5, 11, 0, 1'b1);
    issue_k(0, 0, 0, 0, 1'b1);
    issue(10, 1, 11);

    // A start while busy with different operands must not disturb the running op.
    issue_k(2, 10, 1000, 24, 1'b0);
    repeat (10) @(negedge clk);
    drive(5, 3, 11);
    drain();

    // A start coinciding with done is dropped; one cycle later is accepted.
    issue_k(3, 4, 50, 31, 1'b0);
    t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    drive(6, 2, 7);
    issue_k(5, 3, 13, 8, 1'b0);
    drain();

    // Asynchronous reset in the middle of a multiply aborts with no done.
    issue(65, 17, 3233);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {{(W-1){1'b0}}, busy}, '0);
    check("abort_done", {{(W-1){1'b0}}, done}, '0);
    check("abort_err", {{(W-1){1'b0}}, err}, '0);
    check("abort_result", result, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_k(3, 5, 7, 5, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rn = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 120);
      if (rn < 2) rn = 3;
      rb = {$urandom, $urandom, $urandom, $urandom} % rn;
      if ($urandom_range(0, 7) == 0) rb = rn;
      re = W'($urandom_range(0, 4095));
      issue(rb, re, rn);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_exp.md
Name: mod_exp

Overview:
- Computes result = base^exp mod n for the RSA datapath.
- Sits directly downstream of the private-exponent stage: it consumes e for encryption or d for decryption, together with modulus n, and produces the ciphertext or plaintext.
- Uses right-to-left binary square-and-multiply.
- Contains two parallel bit-serial interleaved modular multipliers.

Parameters:
W, 128, operand width in bits for base, exp, n and result.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
base  input  W  message or ciphertext; must be < n
exp  input  W  exponent (e or d)
n  input  W  modulus; must be >= 2
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; result and err are valid on this cycle
result  output  W  base^exp mod n; held until the next accepted start
err  output  1  operand error flag; held with result

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, err=0, result=0; all internal registers cleared.
- Reset mid-operation: abort immediately, with no done pulse.
- States: IDLE, LOAD, MUL, UPD, FIN.
- IDLE:
  - start=1 latches base, exp and n, then goes to LOAD.
  - start is ignored in every other state; there is no queueing.
- LOAD:
  - If n<2 or base>=n: err_next=1, result_next=0, go to FIN.
  - Else if exp==0: result_next=1, go to FIN.
  - Else: acc=1, sq=base, e_r=exp, go to MUL.
- MUL:
  - Pulse mul_start for one cycle to both mod_mul instances: P1=acc*sq mod n and P2=sq*sq mod n.
  - Wait for mul_done, which arrives exactly W cycles after mul_start; then go to UPD.
- UPD:
  - If e_r[0]: acc=P1.
  - Always: sq=P2, e_r=e_r>>1.
  - If the shifted e_r==0: result_next=acc (the updated value), go to FIN.
  - Else go to MUL.
- FIN: register result and err, pulse done=1 for one cycle, go to IDLE.
- busy is high in LOAD, MUL, UPD and FIN, and low in IDLE.
- Latency: with L = bit length of exp (index of its MSB plus 1), done is asserted exactly L*(W+2)+2 cycles after the start cycle. An error or exp==0 gives done 2 cycles after start.
- A start in the same cycle as done (state FIN) is ignored; a start one cycle later is accepted.
- mod_mul sub-module (a, b, n are W bits; product < n):
  - acc=0; for i=W-1 down to 0, one bit per cycle:
    - acc=2*acc; if acc>=n, acc-=n.
    - If a[i]: acc+=b; if acc>=n, acc-=n.
  - Intermediates are W+1 bits wide, so no overflow is possible.
  - Operands are latched on mul_start; mul_done pulses on the W-th cycle after mul_start.
  - The product holds until the next mul_start.
- All arithmetic is unsigned. Inputs must satisfy a,b < n; the top level guarantees this.

Decomposition:
- Package rsa_pkg: W default constant (RSA_W=128) and the mod_exp state enum (IDLE, LOAD, MUL, UPD, FIN).
- Sub-module mod_mul: bit-serial interleaved modular multiplier, instantiated twice (P1 and P2).
- Both instances use the same clk and rst_n and follow the mul_start/mul_done handshake.

Test Plan:
- W=16; base=4, exp=13, n=497 -> result=445, err=0; done exactly 4*18+2=74 cycles after start.
- W=128; base=65, exp=17, n=3233 -> result=2790, done 652 cycles after start. Then base=2790, exp=2753, n=3233 -> result=65.
- exp=0, base=7, n=11 -> result=1, done 2 cycles after start. base=0, exp=5, n=11 -> result=0, err=0.
- n=1 -> err=1, result=0. base=20, n=11 -> err=1, result=0. Both give done 2 cycles after start.
- Second start pulse while busy, with different operands -> ignored; the first result is correct and only one done pulse is produced.
- Drive rst_n low mid-MUL -> busy, done, err and result go to 0 asynchronously. A new start after reset release (base=3, exp=5, n=7) -> result=5.
